rv_exec_pipe: RTL

// - Parametrised 3-stage (ID / EX / WB) integer execute pipeline for RV32I register-register and register-immediate ALU ops.
// - Successor to the single-cycle control/regfile/ALU datapath; sits between instruction fetch and the retire/trace logic.
// - Adds valid/ready handshakes, full forwarding, reset, illegal-op flagging and an optional I-type path.

---
 rtl/rv_pkg.sv | 45 ++++
 rtl/rv_alu.sv | 35 +++
 rtl/rv_exec_pipe.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared encodings and decode records for the rv_exec_pipe execute pipeline.
// Holds the RV32I opcode/funct fields, the ALU operation set and the funct3 mapping.
package rv_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS0
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    use_imm;
        logic    illegal;
    } dec_t;

    // funct3 meaning when funct7 selects the base (non-alternate) encoding
    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu.sv
// Combinational integer ALU for the EX stage; shifts use the low log2(XLEN) bits of b.
module rv_alu
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_e          op_i,
    input  logic [XLEN-1:0]  a_i,
    input  logic [XLEN-1:0]  b_i,
    output logic [XLEN-1:0]  result_o
);

    localparam int SH_W = $clog2(XLEN);

    logic [SH_W-1:0] shamt;
    assign shamt = b_i[SH_W-1:0];

    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $signed(a_i) >>> shamt;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

endmodule

// File: rtl/rv_exec_pipe.sv
// ID/EX/WB integer execute pipeline with full forwarding and a stallable retire port.
// Decode, register file, operand forwarding and both stage registers live here.
module rv_exec_pipe
    import rv_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int SUPPORT_IMM = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [31:0]           instr,
    output logic                  instr_ready,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_data,
    output logic                  wb_illegal
);

    localparam int NREGS = 2**REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] ridx_t;
    typedef logic [XLEN-1:0]       word_t;

    word_t   regs_q [NREGS];

    logic    ex_valid_q, ex_illegal_q;
    alu_op_e ex_op_q;
    word_t   ex_a_q, ex_b_q;
    ridx_t   ex_rd_q;

    logic    wb_valid_q, wb_illegal_q;
    ridx_t   wb_rd_q;
    word_t   wb_data_q;

    logic    advance;
    word_t   alu_res;

    // A full retire slot that is not being drained freezes the whole pipe.
    assign advance     = !wb_valid_q || wb_ready;
    assign instr_ready = advance;

    logic [6:0] opc, f7;
    logic [2:0] f3;
    ridx_t      rs1, rs2, rd;
    word_t      imm;
    dec_t       dec;

    assign opc = instr[6:0];
    assign f3  = instr[14:12];
    assign f7  = instr[31:25];
    assign rd  = ridx_t'(instr[11:7]);
    assign rs1 = ridx_t'(instr[19:15]);
    assign rs2 = ridx_t'(instr[24:20]);
    assign imm = {{(XLEN-12){instr[31]}}, instr[31:20]};

    always_comb begin
        dec = '{op: ALU_PASS0, use_imm: 1'b0, illegal: 1'b1};
        case (opc)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    dec.op      = base_op(f3);
                    dec.illegal = 1'b0;
                end else if (f7 == F7_ALT && f3 == F3_ADD) begin
                    dec.op      = ALU_SUB;
                    dec.illegal = 1'b0;
                end else if (f7 == F7_ALT && f3 == F3_SR) begin
                    dec.op      = ALU_SRA;
                    dec.illegal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                if (SUPPORT_IMM != 0) begin
                    dec.use_imm = 1'b1;
                    if (f3 == F3_SLL) begin
                        if (f7 == F7_BASE) begin
                            dec.op      = ALU_SLL;
                            dec.illegal = 1'b0;
                        end
                    end else if (f3 == F3_SR) begin
                        if (f7 == F7_BASE) begin
                            dec.op      = ALU_SRL;
                            dec.illegal = 1'b0;
                        end else if (f7 == F7_ALT) begin
                            dec.op      = ALU_SRA;
                            dec.illegal = 1'b0;
                        end
                    end else begin
                        dec.op      = base_op(f3);
                        dec.illegal = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        // Illegal ops and writes to x0 retire a zero result.
        if (dec.illegal || rd == '0) dec.op = ALU_PASS0;
    end

    logic ex_fwd, wb_fwd;
    assign ex_fwd = ex_valid_q && !ex_illegal_q && ex_rd_q != '0;
    assign wb_fwd = wb_valid_q && !wb_illegal_q && wb_rd_q != '0;

    function automatic word_t fwd_sel(input ridx_t idx, input word_t ex_v, input word_t wb_v,
                                      input word_t rf_v, input logic ex_hit_en, input logic wb_hit_en,
                                      input ridx_t ex_rd, input ridx_t wb_rd_idx);
        if (idx == '0)                         return '0;
        else if (ex_hit_en && ex_rd == idx)    return ex_v;
        else if (wb_hit_en && wb_rd_idx == idx) return wb_v;
        else                                   return rf_v;
    endfunction

    word_t ex_a_d, ex_b_d, rs2_val;
    assign ex_a_d  = fwd_sel(rs1, alu_res, wb_data_q, regs_q[rs1], ex_fwd, wb_fwd, ex_rd_q, wb_rd_q);
    assign rs2_val = fwd_sel(rs2, alu_res, wb_data_q, regs_q[rs2], ex_fwd, wb_fwd, ex_rd_q, wb_rd_q);
    assign ex_b_d  = dec.use_imm ? imm : rs2_val;

    // ID -> EX boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            ex_illegal_q <= 1'b0;
            ex_op_q      <= ALU_PASS0;
            ex_a_q       <= '0;
            ex_b_q       <= '0;
            ex_rd_q      <= '0;
        end else if (advance) begin
            ex_valid_q   <= instr_valid;
            ex_illegal_q <= dec.illegal;
            ex_op_q      <= dec.op;
            ex_a_q       <= ex_a_d;
            ex_b_q       <= ex_b_d;
            ex_rd_q      <= rd;
        end
    end

    rv_alu #(.XLEN(XLEN)) u_alu (
        .op_i     (ex_op_q),
        .a_i      (ex_a_q),
        .b_i      (ex_b_q),
        .result_o (alu_res)
    );

    // EX -> WB boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q   <= 1'b0;
            wb_illegal_q <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
        end else if (advance) begin
            wb_valid_q   <= ex_valid_q;
            wb_illegal_q <= ex_illegal_q;
            wb_rd_q      <= ex_rd_q;
            wb_data_q    <= alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (wb_valid_q && wb_ready && wb_rd_q != '0 && !wb_illegal_q) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_illegal = wb_illegal_q;

endmodule
